// File: rtl/mux16_to_1.sv
// ---------------------------------------------------------------------------
// mux16_to_1
//   A 16:1 lane selector for the datapath mux library. It is built as a
//   four-level tree of fifteen mux2_1 cells. Control bit 0 drives the leaf
//   level and control bit 3 drives the root. The module gives the selected
//   lane combinationally and also as a registered copy for pipelined read
//   paths. Two of these plus one mux2_1 make up one bit of a 32:1
//   register-file read port.
//
// Ports
//   clk      in   1          rising-edge clock; used only by out_q
//   reset_n  in   1          asynchronous active-low reset; clears out_q
//   in       in   16*WIDTH   lane k = in[k*WIDTH +: WIDTH], k = 0..15
//   control  in   4          lane select, unsigned 0..15
//   out      out  WIDTH      combinational selected lane
//   out_q    out  WIDTH      out registered on each rising clk edge
//
// This block has no handshake. The inputs are sampled on every rising edge,
// and out_q is valid one cycle after the inputs that produced it.
// ---------------------------------------------------------------------------

// Basic 2:1 cell, out = sel ? i1 : i0.
// The conditional operator keeps the library semantics for an unknown select:
// if i0 and i1 agree, the result is their common value. If they differ, the
// result is X.
module mux2_1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? i1 : i0;

endmodule

module mux16_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [16*WIDTH-1:0]   in,
    input  logic [3:0]            control,
    output logic [WIDTH-1:0]      out,
    output logic [WIDTH-1:0]      out_q
);

    // Unpacked views of the lanes and of each tree level.
    logic [WIDTH-1:0] lane [16];
    logic [WIDTH-1:0] lvl0 [8];
    logic [WIDTH-1:0] lvl1 [4];
    logic [WIDTH-1:0] lvl2 [2];
    logic [WIDTH-1:0] root;

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_lane
            assign lane[k] = in[k*WIDTH +: WIDTH];
        end

        // Level 0 picks within the adjacent pairs (2j, 2j+1).
        for (k = 0; k < 8; k++) begin : g_lvl0
            mux2_1 #(.WIDTH(WIDTH)) u_cell (
                .i0  (lane[2*k]),
                .i1  (lane[2*k+1]),
                .sel (control[0]),
                .out (lvl0[k])
            );
        end

        for (k = 0; k < 4; k++) begin : g_lvl1
            mux2_1 #(.WIDTH(WIDTH)) u_cell (
                .i0  (lvl0[2*k]),
                .i1  (lvl0[2*k+1]),
                .sel (control[1]),
                .out (lvl1[k])
            );
        end

        for (k = 0; k < 2; k++) begin : g_lvl2
            mux2_1 #(.WIDTH(WIDTH)) u_cell (
                .i0  (lvl1[2*k]),
                .i1  (lvl1[2*k+1]),
                .sel (control[2]),
                .out (lvl2[k])
            );
        end
    endgenerate

    mux2_1 #(.WIDTH(WIDTH)) u_root (
        .i0  (lvl2[0]),
        .i1  (lvl2[1]),
        .sel (control[3]),
        .out (root)
    );

    // The combinational result does not depend on clk or reset_n.
    assign out = root;

    // The pipelined copy has no enable and captures every edge.
    // An asynchronous reset drops any value still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= root;
        end
    end

endmodule

// File: tb/tb_mux16_to_1.sv
// ---------------------------------------------------------------------------
// tb_mux16_to_1
//   Self-checking bench for mux16_to_1 with one WIDTH=1 and one WIDTH=8
//   instance. The reference picks a lane by shifting the input bus. A
//   per-edge expected queue models out_q. A negedge compare process checks
//   every cycle, and directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_mux16_to_1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  in1;
    logic [3:0]   ctl1;
    logic [0:0]   out1, out_q1;
    logic [127:0] in8;
    logic [3:0]   ctl8;
    logic [7:0]   out8, out_q8;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Expected out_q per instance, refreshed at each rising edge.
    logic [0:0] exp1_q[$];
    logic [7:0] exp8_q[$];

    mux16_to_1 #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in1),
        .control (ctl1),
        .out     (out1),
        .out_q   (out_q1)
    );

    mux16_to_1 #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in8),
        .control (ctl8),
        .out     (out8),
        .out_q   (out_q8)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [0:0] ref1(input logic [15:0] v, input logic [3:0] c);
        logic [15:0] s;
        s = v >> c;
        return s[0];
    endfunction

    function automatic logic [7:0] ref8(input logic [127:0] v, input logic [3:0] c);
        logic [127:0] s;
        s = v >> (int'(c) * 8);
        return s[7:0];
    endfunction

    always @(posedge clk) begin
        exp1_q.delete();
        exp8_q.delete();
        exp1_q.push_back(reset_n ? ref1(in1, ctl1) : 1'b0);
        exp8_q.push_back(reset_n ? ref8(in8, ctl8) : 8'h00);
    end

    always @(negedge reset_n) begin
        exp1_q.delete();
        exp8_q.delete();
        exp1_q.push_back(1'b0);
        exp8_q.push_back(8'h00);
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out1",   128'(out1),   128'(ref1(in1, ctl1)));
            chk("cyc_out8",   128'(out8),   128'(ref8(in8, ctl8)));
            chk("cyc_out_q1", 128'(out_q1), 128'(exp1_q[0]));
            chk("cyc_out_q8", 128'(out_q8), 128'(exp8_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp1_q.push_back(1'b0);
        exp8_q.push_back(8'h00);
        reset_n = 1'b0;
        in1 = '0; ctl1 = '0; in8 = '0; ctl8 = '0;
        chk_en = 1'b1;
        #1;
        chk("rst_out_q1", 128'(out_q1), 128'h0);
        chk("rst_out_q8", 128'(out_q8), 128'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single one in lane 0, control sweep.
        in1 = 16'h0001;
        for (int c = 0; c < 16; c++) begin
            ctl1 = 4'(c);
            #1 chk("t1_out", 128'(out1), (c == 0) ? 128'h1 : 128'h0);
            @(posedge clk);
            #1 chk("t1_out_q", 128'(out_q1), (c == 0) ? 128'h1 : 128'h0);
            #1;
        end

        // Walking one: its own lane selects 1 and the partner lane selects 0.
        for (int k = 0; k < 16; k++) begin
            in1  = 16'h0001 << k;
            ctl1 = 4'(k);
            #1 chk("t2_hit", 128'(out1), 128'h1);
            ctl1 = 4'(k ^ 1);
            #1 chk("t2_miss", 128'(out1), 128'h0);
            @(posedge clk);
            #2;
        end

        // Byte lanes A0+k, lane 13 selected.
        for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'hA0 + 8'(k);
        ctl8 = 4'd13;
        #1 chk("t3_out", 128'(out8), 128'hAD);
        @(posedge clk);
        #1 chk("t3_out_q", 128'(out_q8), 128'hAD);
        #1;

        // Lane 7 changes between edges.
        ctl8 = 4'd7;
        in8[56 +: 8] = 8'h11;
        @(posedge clk);
        #1 chk("t4_q_load", 128'(out_q8), 128'h11);
        in8[56 +: 8] = 8'h22;
        #1 chk("t4_out_a", 128'(out8), 128'h22);
        chk("t4_q_hold_a", 128'(out_q8), 128'h11);
        in8[56 +: 8] = 8'h33;
        #1 chk("t4_out_b", 128'(out8), 128'h33);
        chk("t4_q_hold_b", 128'(out_q8), 128'h11);
        @(posedge clk);
        #1 chk("t4_q_edge", 128'(out_q8), 128'h33);

        // Asynchronous reset between edges.
        in8[56 +: 8] = 8'hFF;
        @(posedge clk);
        #1 chk("t5_q_ff", 128'(out_q8), 128'hFF);
        #1 reset_n = 1'b0;
        #1 chk("t5_q_clr", 128'(out_q8), 128'h0);
        chk("t5_out_live", 128'(out8), 128'hFF);
        #1 reset_n = 1'b1;
        #0 chk("t5_q_still0", 128'(out_q8), 128'h0);
        @(posedge clk);
        #1 chk("t5_q_reload", 128'(out_q8), 128'hFF);
        #1;

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            in1  = 16'($urandom);
            ctl1 = 4'($urandom_range(0, 15));
            in8  = {$urandom, $urandom, $urandom, $urandom};
            ctl8 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        @(posedge clk);
        #2 chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
